// File: rtl/byte_selector.sv
// ---------------------------------------------------------------------------
// byte_selector
//   Extracts one 8-bit lane from a multi-byte word. Lanes are little-endian:
//   offset 0 selects the least-significant byte. Used as the lane-select
//   stage for byte loads and byte-wise datapath slicing.
//
//   Parameters
//     IN_BYTES : number of byte lanes in io_in (power of two, >= 2)
//     OFFSET_W : width of io_offset, must equal log2(IN_BYTES)
//     OUT_REG  : 0 = combinational output, 1 = one-cycle registered output
//
//   Ports
//     clock     : rising-edge clock, only used when OUT_REG = 1
//     reset     : synchronous active-high reset, only used when OUT_REG = 1
//     io_offset : byte-lane index
//     io_in     : source word, 8*IN_BYTES bits
//     io_out    : selected byte
// ---------------------------------------------------------------------------
module byte_selector #(
  parameter int IN_BYTES = 4,
  parameter int OFFSET_W = 2,
  parameter bit OUT_REG  = 1'b0
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [OFFSET_W-1:0]     io_offset,
  input  logic [8*IN_BYTES-1:0]   io_in,
  output logic [7:0]              io_out
);

  if ((IN_BYTES < 2) || ((IN_BYTES & (IN_BYTES - 1)) != 0)) begin : g_bad_in_bytes
    $error("byte_selector: IN_BYTES must be a power of two and at least 2");
  end

  if (OFFSET_W != $clog2(IN_BYTES)) begin : g_bad_offset_w
    $error("byte_selector: OFFSET_W must equal log2(IN_BYTES)");
  end

  // Lane-select function: each lane is gated by an exact index match, so a
  // lane that is not selected can never reach the result, even if it holds X.
  function automatic logic [7:0] lane_select(input logic [OFFSET_W-1:0] idx,
                                             input logic [8*IN_BYTES-1:0] word);
    logic [7:0] sel;
    sel = 8'h00;
    for (int i = 0; i < IN_BYTES; i++) begin
      if (idx == OFFSET_W'(i)) begin
        sel = word[8*i +: 8];
      end
    end
    return sel;
  endfunction

  // Stage p0: combinational lane mux
  logic [7:0] sel_p0;

  always_comb begin
    sel_p0 = lane_select(io_offset, io_in);
  end

  if (OUT_REG) begin : g_reg
    // Stage p1: optional output register; reset wins over the load
    logic [7:0] out_p1;

    always_ff @(posedge clock) begin
      if (reset) begin
        out_p1 <= 8'h00;
      end else begin
        out_p1 <= sel_p0;
      end
    end

    assign io_out = out_p1;
  end else begin : g_comb
    // Clock and reset exist only for the uniform interface in this mode.
    logic unused_clk_rst;
    assign unused_clk_rst = &{1'b0, clock, reset};

    assign io_out = sel_p0;
  end

endmodule

// File: tb/tb_byte_selector.sv
module tb_byte_selector;

  logic        clock;
  logic        rst_c;
  logic        rst_r;
  logic [1:0]  off_c;
  logic [31:0] in_c;
  logic [7:0]  out_c;
  logic [1:0]  off_r;
  logic [31:0] in_r;
  logic [7:0]  out_r;

  int n_cmp;
  int n_bad;

  byte_selector #(.IN_BYTES(4), .OFFSET_W(2), .OUT_REG(1'b0)) dut_comb (
    .clock     (clock),
    .reset     (rst_c),
    .io_offset (off_c),
    .io_in     (in_c),
    .io_out    (out_c)
  );

  byte_selector #(.IN_BYTES(4), .OFFSET_W(2), .OUT_REG(1'b1)) dut_reg (
    .clock     (clock),
    .reset     (rst_r),
    .io_offset (off_r),
    .io_in     (in_r),
    .io_out    (out_r)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    string       name;
    logic [31:0] in;
    logic [1:0]  off;
    logic [7:0]  exp;
  } vec_t;

  vec_t tbl[11];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%02h, required 0x%02h", name, act, exp);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_c = 1'b0;
    rst_r = 1'b1;
    off_c = 2'd0;
    in_c  = 32'h0;
    off_r = 2'd0;
    in_r  = 32'h0;

    tbl[0]  = '{"sweep_off0",   32'h12345678, 2'd0, 8'h78};
    tbl[1]  = '{"sweep_off1",   32'h12345678, 2'd1, 8'h56};
    tbl[2]  = '{"sweep_off2",   32'h12345678, 2'd2, 8'h34};
    tbl[3]  = '{"sweep_off3",   32'h12345678, 2'd3, 8'h12};
    tbl[4]  = '{"deadbeef_off2", 32'hDEADBEEF, 2'd2, 8'hAD};
    tbl[5]  = '{"cafef00d_off2", 32'hCAFEF00D, 2'd2, 8'hFE};
    tbl[6]  = '{"isolate_zero", 32'hFFFF00FF, 2'd1, 8'h00};
    tbl[7]  = '{"isolate_ones", 32'h0000FF00, 2'd1, 8'hFF};
    tbl[8]  = '{"msb_lane3",    32'h80000000, 2'd3, 8'h80};
    tbl[9]  = '{"low_lane_ff",  32'h000000FF, 2'd0, 8'hFF};
    tbl[10] = '{"low_lane_00",  32'hFFFFFF00, 2'd0, 8'h00};

    // Combinational configuration: table vectors, no clock edge required
    @(negedge clock);
    for (int i = 0; i < 11; i++) begin
      in_c  = tbl[i].in;
      off_c = tbl[i].off;
      #1;
      check(tbl[i].name, out_c, tbl[i].exp);
    end

    // Reset held high for 5 cycles has no effect on the combinational path
    rst_c = 1'b1;
    in_c  = 32'hA5C3E781;
    off_c = 2'd3;
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      check("comb_reset_hold", out_c, 8'hA5);
    end
    off_c = 2'd0;
    #1;
    check("comb_reset_off0", out_c, 8'h81);
    rst_c = 1'b0;

    // Random sweep against a shift-and-mask model
    for (int k = 0; k < 1000; k++) begin
      logic [31:0] r_in;
      logic [1:0]  r_off;
      logic [7:0]  r_exp;
      r_in  = $urandom;
      r_off = 2'($urandom_range(0, 3));
      r_exp = 8'((r_in >> (8 * r_off)) & 32'hFF);
      in_c  = r_in;
      off_c = r_off;
      #1;
      check("comb_random", out_c, r_exp);
    end

    // Registered configuration
    @(negedge clock);
    rst_r = 1'b1;
    in_r  = 32'h12345678;
    off_r = 2'd0;
    @(posedge clock); #1;
    check("reg_reset_edge", out_r, 8'h00);

    rst_r = 1'b0;
    @(posedge clock); #1;
    check("reg_first_load", out_r, 8'h78);

    off_r = 2'd3;
    #1;
    check("reg_hold_before_edge", out_r, 8'h78);
    @(posedge clock); #1;
    check("reg_off3_after_edge", out_r, 8'h12);

    in_r = 32'hDEADBEEF;
    off_r = 2'd1;
    @(posedge clock); #1;
    check("reg_deadbeef_off1", out_r, 8'hBE);

    rst_r = 1'b1;
    #1;
    check("reg_reset_not_yet", out_r, 8'hBE);
    @(posedge clock); #1;
    check("reg_reset_midstream", out_r, 8'h00);

    in_r  = 32'hFFFFFFFF;
    off_r = 2'd2;
    @(posedge clock); #1;
    check("reg_reset_priority", out_r, 8'h00);

    rst_r = 1'b0;
    @(posedge clock); #1;
    check("reg_after_release", out_r, 8'hFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
